// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: D-stage branch sequencer (operand wait, compare, PC redirect, statistics)
module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    output logic [2:0]       cmp_op,
    input  logic             cmp_flag,
    output logic             stall_d,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;
    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] tgt_q;
    logic [2:0]  cur_op;
    logic        op_bad;
    logic        ops_ok;
    logic        taken;
    logic [31:0] tgt;
    // Operand readiness, taken decision and target; the target is folded at accept so only one register is kept
    always_comb begin
        cur_op  = (state == IDLE) ? br_op : op_q;
        op_bad  = cur_op[2:1] == 2'b11;
        ops_ok  = op_bad | (rs_ready & ((cur_op[2:1] != 2'b00) | rt_ready));
        taken   = ~op_bad & cmp_flag;
        tgt     = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        cmp_op  = cur_op;
        stall_d = ~reset & (((state == IDLE) & br_valid & ~flush) | (state == WAIT));
    end
    // Branch FSM; flush aborts everything and suppresses redirect and counter updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= '0;
            tgt_q          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_cnt         <= '0;
            taken_cnt      <= '0;
            stall_cnt      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (br_valid) begin
                        op_q  <= br_op;
                        tgt_q <= tgt;
                        state <= ops_ok ? EVAL : WAIT;
                    end
                    WAIT: begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                        if (ops_ok) state <= EVAL;
                    end
                    EVAL: begin
                        br_cnt <= br_cnt + CNT_W'(1);
                        if (taken) begin
                            taken_cnt      <= taken_cnt + CNT_W'(1);
                            redirect_valid <= 1'b1;
                            redirect_pc    <= tgt_q;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized checks against a transaction-level branch model
module tb_branch_resolve_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_op = '0;
    logic        rs_ready = 1'b0;
    logic        rt_ready = 1'b0;
    logic [31:0] pc_d = '0;
    logic [15:0] imm16 = '0;
    logic        cmp_flag = 1'b0;
    logic [2:0]  cmp_op, cmp_op2;
    logic        stall_d, stall_d2, rv, rv2;
    logic [31:0] rpc, rpc2;
    logic [15:0] br_cnt, taken_cnt, stall_cnt;
    logic [1:0]  br_cnt2, taken_cnt2, stall_cnt2;
    int          checks = 0;
    int          errors = 0;
    int          m_br = 0, m_taken = 0, m_stall = 0;
    logic [31:0] m_pc = '0;

    branch_resolve_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush), .br_valid(br_valid), .br_op(br_op),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_d(pc_d), .imm16(imm16),
        .cmp_op(cmp_op), .cmp_flag(cmp_flag), .stall_d(stall_d), .redirect_valid(rv),
        .redirect_pc(rpc), .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    branch_resolve_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .br_valid(br_valid), .br_op(br_op),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_d(pc_d), .imm16(imm16),
        .cmp_op(cmp_op2), .cmp_flag(cmp_flag), .stall_d(stall_d2), .redirect_valid(rv2),
        .redirect_pc(rpc2), .br_cnt(br_cnt2), .taken_cnt(taken_cnt2), .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("br_cnt", 32'(br_cnt), 32'(m_br) & 32'hFFFF);
        chk("taken_cnt", 32'(taken_cnt), 32'(m_taken) & 32'hFFFF);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall) & 32'hFFFF);
        chk("br_cnt_w2", 32'(br_cnt2), 32'(m_br) & 32'h3);
        chk("taken_cnt_w2", 32'(taken_cnt2), 32'(m_taken) & 32'h3);
        chk("stall_cnt_w2", 32'(stall_cnt2), 32'(m_stall) & 32'h3);
        chk("redirect_pc", rpc, m_pc);
        chk("redirect_pc_w2", rpc2, m_pc);
    endtask

    task automatic zero_model();
        m_br = 0;
        m_taken = 0;
        m_stall = 0;
        m_pc = '0;
    endtask

    // One branch: rs becomes ready at cycle drs, rt at cycle drt (cycle 0 = first presentation)
    task automatic run_branch(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                              input int drs, input int drt, input logic flag);
        logic bad, tk;
        int   w;
        bad = op[2:1] == 2'b11;
        w   = bad ? 0 : (op[2:1] == 2'b00) ? ((drs > drt) ? drs : drt) : drs;
        tk  = !bad && flag;
        for (int c = 0; c <= w + 2; c++) begin
            @(negedge clk);
            br_valid = (c <= w + 1);
            br_op    = op;
            pc_d     = pc;
            imm16    = imm;
            rs_ready = (c >= drs);
            rt_ready = (c >= drt);
            cmp_flag = flag;
            #1;
            chk("stall_d", 32'(stall_d), 32'(c <= w));
            chk("stall_d_w2", 32'(stall_d2), 32'(c <= w));
            chk("cmp_op", 32'(cmp_op), 32'(op));
            chk("cmp_op_w2", 32'(cmp_op2), 32'(op));
            chk("redirect_valid", 32'(rv), 32'(c == w + 2 && tk));
            chk("redirect_valid_w2", 32'(rv2), 32'(c == w + 2 && tk));
        end
        m_stall += w;
        m_br++;
        if (tk) begin
            m_taken++;
            m_pc = pc + 32'd4 + 32'(int'($signed(imm)) * 4);
        end
        check_all();
        br_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("idle_stall", 32'(stall_d), 32'd0);
            chk("idle_rv", 32'(rv), 32'd0);
            chk("idle_cmp_op", 32'(cmp_op), 32'd0);
            check_all();
        end
        // beq taken, no wait
        run_branch(3'b000, 32'h0000_3000, 16'h0004, 0, 0, 1'b1);
        chk("beq_target", rpc, 32'h0000_3014);
        // bne waiting 3 cycles on rt, not taken
        run_branch(3'b001, 32'h0000_4000, 16'h0010, 0, 3, 1'b0);
        // bgez in WAIT, flushed
        @(negedge clk);
        br_valid = 1'b1; br_op = 3'b101; rs_ready = 1'b0; rt_ready = 1'b1;
        pc_d = 32'h0000_5000; imm16 = 16'h0008; cmp_flag = 1'b1;
        #1 chk("fl_wait_accept", 32'(stall_d), 32'd1);
        @(negedge clk);
        #1 chk("fl_wait_stall", 32'(stall_d), 32'd1);
        m_stall++;
        @(negedge clk);
        flush = 1'b1; rs_ready = 1'b1;
        #1 chk("fl_wait_flush_stall", 32'(stall_d), 32'd1);
        @(negedge clk);
        flush = 1'b0; br_valid = 1'b0;
        #1 chk("fl_wait_after_stall", 32'(stall_d), 32'd0);
        chk("fl_wait_after_rv", 32'(rv), 32'd0);
        @(negedge clk);
        #1 chk("fl_wait_rv", 32'(rv), 32'd0);
        check_all();
        run_branch(3'b000, 32'h0000_6000, 16'hFFFF, 0, 0, 1'b1);
        // flush while a branch is offered in IDLE
        @(negedge clk);
        br_valid = 1'b1; br_op = 3'b000; rs_ready = 1'b1; rt_ready = 1'b1; cmp_flag = 1'b1; flush = 1'b1;
        #1 chk("fl_idle_stall", 32'(stall_d), 32'd0);
        @(negedge clk);
        flush = 1'b0; br_valid = 1'b0;
        #1 chk("fl_idle_next_rv", 32'(rv), 32'd0);
        @(negedge clk);
        #1 chk("fl_idle_rv", 32'(rv), 32'd0);
        check_all();
        // flush in EVAL
        @(negedge clk);
        br_valid = 1'b1; br_op = 3'b000; pc_d = 32'h0000_7000; imm16 = 16'h0001;
        #1 chk("fl_eval_accept", 32'(stall_d), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_eval_stall", 32'(stall_d), 32'd0);
        @(negedge clk);
        flush = 1'b0; br_valid = 1'b0;
        #1 chk("fl_eval_rv", 32'(rv), 32'd0);
        check_all();
        // invalid ops resolve not-taken without waiting
        run_branch(3'b111, 32'h0000_8000, 16'h0004, 5, 5, 1'b1);
        run_branch(3'b110, 32'h0000_9000, 16'h0004, 5, 5, 1'b1);
        // wrap of target and narrow counters
        for (int i = 0; i < 5; i++) run_branch(3'b000, 32'hFFFF_FFF0, 16'h0002, 0, 0, 1'b1);
        chk("wrap_target", rpc, 32'hFFFF_FFFC);
        chk("wrap_taken_w2", 32'(taken_cnt2), 32'(m_taken) & 32'h3);
        // asynchronous reset while waiting
        @(negedge clk);
        br_valid = 1'b1; br_op = 3'b000; rs_ready = 1'b0; rt_ready = 1'b1;
        #1 chk("rst_wait_accept", 32'(stall_d), 32'd1);
        @(negedge clk);
        #1 chk("rst_wait_stall", 32'(stall_d), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rst_async_stall", 32'(stall_d), 32'd0);
        zero_model();
        @(negedge clk);
        reset = 1'b0; br_valid = 1'b0;
        #1 check_all();
        // asynchronous reset during the redirect pulse
        @(negedge clk);
        br_valid = 1'b1; br_op = 3'b000; rs_ready = 1'b1; rt_ready = 1'b1; cmp_flag = 1'b1;
        pc_d = 32'h0000_A000; imm16 = 16'h0003;
        @(negedge clk);
        @(negedge clk);
        br_valid = 1'b0;
        #1 chk("rst_rv_before", 32'(rv), 32'd1);
        reset = 1'b1;
        #1 chk("rst_rv_async", 32'(rv), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_all();
        // randomized branches
        for (int i = 0; i < 150; i++) begin
            run_branch(3'($urandom_range(0, 7)), $urandom, 16'($urandom),
                       ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                       ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                       1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
